// File: rtl/leitor_registradores_if.sv
// rtl/leitor_registradores_if.sv - register-bank read port plus indexed dump stream
//
// Bundles the two buses of the dump reader:
//   raddr/rdata                        : combinational read port of the register bank
//   dout/dout_idx/dout_valid/dout_ready: valid/ready stream of captured register values
// master = the dump reader, slave = bank + downstream sink.
interface leitor_registradores_if #(
    parameter int AW = 5,
    parameter int DW = 32
);
    logic [AW-1:0] raddr;
    logic [DW-1:0] rdata;
    logic [DW-1:0] dout;
    logic [AW-1:0] dout_idx;
    logic          dout_valid;
    logic          dout_ready;

    modport master (
        output raddr,
        input  rdata,
        output dout,
        output dout_idx,
        output dout_valid,
        input  dout_ready
    );

    modport slave (
        input  raddr,
        output rdata,
        input  dout,
        input  dout_idx,
        input  dout_valid,
        output dout_ready
    );
endinterface

// File: rtl/leitor_registradores.sv
// rtl/leitor_registradores.sv - register-file dump reader with index tags and XOR checksum
//
// On start, walks indices 0..NREGS-1 through the bank read port, skipping
// cycles where the datapath is in a register-write state, and streams each
// value out tagged with its index. A running XOR checksum is kept.
//
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   start      : dump request, sampled only while idle
//   estado     : datapath control state (4'b0110/4'b0111 = register write)
//   bus        : master side of the read port and the dump stream
//   busy       : dump in progress
//   done       : one-cycle pulse after the last beat is accepted
//   checksum   : XOR of all values captured in the current/last dump
module leitor_registradores #(
    parameter int NREGS = 32,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [3:0]             estado,
    leitor_registradores_if.master bus,
    output logic                   busy,
    output logic                   done,
    output logic [DW-1:0]          checksum
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_SEND = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

    state_t        state;
    state_t        state_nxt;
    logic [AW-1:0] idx;
    logic [DW-1:0] dout_q;
    logic [AW-1:0] dout_idx_q;
    logic          write_state;
    logic          handshake;

    // The bank may be mid-write in these states, so its read data is not trusted.
    assign write_state = (estado == 4'b0110) || (estado == 4'b0111);
    assign handshake   = (state == S_SEND) && bus.dout_ready;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_READ;
                end
            end
            S_READ: begin
                if (!write_state) begin
                    state_nxt = S_SEND;
                end
            end
            S_SEND: begin
                if (bus.dout_ready) begin
                    state_nxt = (idx == LAST_IDX) ? S_DONE : S_READ;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Datapath: walking index, captured beat and checksum
    always_ff @(posedge clk) begin
        if (reset) begin
            idx        <= '0;
            dout_q     <= '0;
            dout_idx_q <= '0;
            checksum   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        idx      <= '0;
                        checksum <= '0;
                    end
                end
                S_READ: begin
                    if (!write_state) begin
                        dout_q     <= bus.rdata;
                        dout_idx_q <= idx;
                        checksum   <= checksum ^ bus.rdata;
                    end
                end
                S_SEND: begin
                    // The index stops at the last register; it never wraps.
                    if (handshake && (idx != LAST_IDX)) begin
                        idx <= idx + AW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs
    always_comb begin
        busy           = (state != S_IDLE);
        done           = (state == S_DONE);
        bus.dout_valid = (state == S_SEND);
        bus.raddr      = (state == S_IDLE) ? '0 : idx;
    end

    assign bus.dout     = dout_q;
    assign bus.dout_idx = dout_idx_q;

endmodule

// File: tb/tb_leitor_registradores.sv
// tb/tb_leitor_registradores.sv - self-checking bench for leitor_registradores
module tb_leitor_registradores;
    localparam int NREGS = 32;
    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int MAXC  = 400;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [3:0]    estado;
    logic          busy;
    logic          done;
    logic [DW-1:0] checksum;
    logic [DW-1:0] bank [NREGS];

    leitor_registradores_if #(.AW(AW), .DW(DW)) bus ();

    assign bus.rdata = bank[bus.raddr];

    leitor_registradores #(.NREGS(NREGS), .AW(AW), .DW(DW)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .estado   (estado),
        .bus      (bus),
        .busy     (busy),
        .done     (done),
        .checksum (checksum)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    // Planned timeline: per register, write-state cycles at the start of its
    // read and ready-low cycles while its beat is offered.
    int         s_len [NREGS];
    int         w_len [NREGS];
    logic [3:0] est_seq   [MAXC];
    logic       rdy_seq   [MAXC];
    logic       exp_valid [MAXC];
    int         exp_idx   [MAXC];
    int         exp_raddr [MAXC];

    typedef struct {
        int          stall_reg;
        int          stall_len;
        int          wait_reg;
        int          wait_len;
        int          restart_cyc;
        int          exp_done;
        logic [31:0] exp_cs;
    } vec_t;

    vec_t tbl [4];

    int          got_done, beats, ndone, found;
    logic [31:0] exp_cs;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] bank_xor();
        logic [31:0] x = '0;
        for (int i = 0; i < NREGS; i++) x ^= bank[i];
        return x;
    endfunction

    task automatic set_plan(input int sr, input int sl, input int wr, input int wl);
        for (int k = 0; k < NREGS; k++) begin
            s_len[k] = (k == sr) ? sl : 0;
            w_len[k] = (k == wr) ? wl : 0;
        end
    endtask

    task automatic build_timeline(input bit rnd, output int done_at);
        int t;
        for (int c = 0; c < MAXC; c++) begin
            est_seq[c]   = rnd ? 4'($urandom_range(0, 15)) : 4'b0000;
            rdy_seq[c]   = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            exp_valid[c] = 1'b0;
            exp_idx[c]   = 0;
            exp_raddr[c] = -1;
        end
        t = 1;
        for (int k = 0; k < NREGS; k++) begin
            for (int j = 0; j < s_len[k]; j++) begin
                est_seq[t + j]   = rnd ? (4'b0110 | 4'($urandom_range(0, 1))) : 4'b0110;
                exp_raddr[t + j] = k;
            end
            t += s_len[k];
            if (est_seq[t] == 4'b0110 || est_seq[t] == 4'b0111) est_seq[t] = 4'b0000;
            exp_raddr[t] = k;
            t++;
            for (int j = 0; j <= w_len[k]; j++) begin
                exp_valid[t + j] = 1'b1;
                exp_idx[t + j]   = k;
                rdy_seq[t + j]   = (j == w_len[k]);
            end
            t += w_len[k] + 1;
        end
        done_at = t;
    endtask

    // Start at edge 0, then play the timeline and compare every cycle.
    task automatic run_dump(input bit rnd, input int restart_cyc,
                            output int gdone, output int nbeats, output int nd);
        int done_at;
        build_timeline(rnd, done_at);
        gdone  = -1;
        nbeats = 0;
        nd     = 0;
        start  = 1'b1;
        estado = 4'b0000;
        bus.dout_ready = 1'b1;
        @(posedge clk); #1;
        for (int c = 1; c < done_at + 3 && c < MAXC; c++) begin
            estado         = est_seq[c];
            bus.dout_ready = rdy_seq[c];
            start          = (c == restart_cyc);
            @(negedge clk);
            check($sformatf("valid@%0d", c), 64'(bus.dout_valid), 64'(exp_valid[c]));
            if (exp_valid[c]) begin
                check($sformatf("idx@%0d", c), 64'(bus.dout_idx), 64'(exp_idx[c]));
                check($sformatf("dout@%0d", c), 64'(bus.dout), 64'(bank[exp_idx[c]]));
            end
            if (exp_raddr[c] >= 0)
                check($sformatf("raddr@%0d", c), 64'(bus.raddr), 64'(exp_raddr[c]));
            if (c == 1)
                check("checksum_cleared", 64'(checksum), 64'(0));
            check($sformatf("busy@%0d", c), 64'(busy), 64'(c <= done_at));
            check($sformatf("done@%0d", c), 64'(done), 64'(c == done_at));
            if (bus.dout_valid && bus.dout_ready) nbeats++;
            if (done) begin
                nd++;
                gdone = c;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
    endtask

    initial begin
        // Basic, backpressure, write-state stall, combined with a start while busy.
        tbl[0] = '{-1, 0, -1, 0, -1, 65, 32'h00000020};
        tbl[1] = '{-1, 0,  5, 3, -1, 68, 32'h00000020};
        tbl[2] = '{10, 4, -1, 0, -1, 69, 32'h00000020};
        tbl[3] = '{10, 4,  5, 3, 30, 72, 32'h00000020};

        reset = 1'b1;
        start = 1'b0;
        estado = 4'b0000;
        bus.dout_ready = 1'b1;
        for (int i = 0; i < NREGS; i++) bank[i] = 32'(i + 1);
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_valid", 64'(bus.dout_valid), 64'(0));
        check("rst_raddr", 64'(bus.raddr), 64'(0));
        check("rst_dout", 64'(bus.dout), 64'(0));
        check("rst_idx", 64'(bus.dout_idx), 64'(0));
        check("rst_cs", 64'(checksum), 64'(0));
        reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 4; i++) begin
            set_plan(tbl[i].stall_reg, tbl[i].stall_len, tbl[i].wait_reg, tbl[i].wait_len);
            run_dump(1'b0, tbl[i].restart_cyc, got_done, beats, ndone);
            check($sformatf("tbl%0d_done_cycle", i), 64'(got_done), 64'(tbl[i].exp_done));
            check($sformatf("tbl%0d_done_count", i), 64'(ndone), 64'(1));
            check($sformatf("tbl%0d_beats", i), 64'(beats), 64'(NREGS));
            check($sformatf("tbl%0d_checksum", i), 64'(checksum), 64'(tbl[i].exp_cs));
        end

        // Checksum hold: bank changes after done, no new start.
        bank[3] = 32'hDEADBEEF;
        repeat (5) @(posedge clk);
        #1;
        @(negedge clk);
        check("hold_checksum", 64'(checksum), 64'(32'h00000020));
        check("hold_idle", 64'(busy), 64'(0));
        @(posedge clk); #1;
        set_plan(-1, 0, -1, 0);
        run_dump(1'b0, -1, got_done, beats, ndone);
        check("hold_new_checksum", 64'(checksum), 64'(32'h00000020 ^ 32'h4 ^ 32'hDEADBEEF));
        for (int i = 0; i < NREGS; i++) bank[i] = 32'(i + 1);

        // Reset mid-dump while beat 20 is offered.
        found = 0;
        start = 1'b1;
        estado = 4'b0000;
        bus.dout_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 200 && found == 0; c++) begin
            @(negedge clk);
            if (bus.dout_valid && bus.dout_idx == AW'(20)) found = 1;
            else begin
                @(posedge clk); #1;
            end
        end
        check("rstmid_reached_beat20", 64'(found), 64'(1));
        reset = 1'b1;
        bus.dout_ready = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("rstmid_valid", 64'(bus.dout_valid), 64'(0));
        check("rstmid_busy", 64'(busy), 64'(0));
        check("rstmid_cs", 64'(checksum), 64'(0));
        check("rstmid_idx", 64'(bus.dout_idx), 64'(0));
        reset = 1'b0;
        bus.dout_ready = 1'b1;
        @(posedge clk); #1;
        run_dump(1'b0, -1, got_done, beats, ndone);
        check("rstmid_redump_done", 64'(got_done), 64'(65));
        check("rstmid_redump_beats", 64'(beats), 64'(NREGS));

        // Randomized dumps: random bank contents, stalls, backpressure and estado noise.
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < NREGS; i++) begin
                bank[i]  = $urandom;
                s_len[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
                w_len[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            end
            exp_cs = bank_xor();
            run_dump(1'b1, (r == 2) ? 20 : -1, got_done, beats, ndone);
            check($sformatf("rnd%0d_beats", r), 64'(beats), 64'(NREGS));
            check($sformatf("rnd%0d_done_count", r), 64'(ndone), 64'(1));
            check($sformatf("rnd%0d_checksum", r), 64'(checksum), 64'(exp_cs));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
